seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_scan.sv | 107 ++++++++++
 tb/tb_seg7_scan.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// seg7_scan -- multiplexed driver for a six-digit, common-anode 7-segment display.
//
// Each digit gets a slot of DIV clocks. The first BLANK clocks of a slot are
// dark so the previous digit's pattern cannot ghost onto the next anode. The
// remaining clocks light that digit. All six segment patterns are captured
// into a snapshot at the end of a frame, so one frame never mixes old and new
// data.
//
// Ports:
//   m_clock      system clock; all state changes on its rising edge
//   p_reset      asynchronous reset, active high
//   digit_0..5   segment patterns (bit0=a .. bit6=g, bit7=dp), 1 = lit
//   enable       1 = scanning; 0 = display dark, scan held at digit 0
//   bright[3:0]  (SEG7_SCAN_DIM_EN only) PWM duty in 16ths; 0 = dark
//   seg_n[7:0]   shared segment bus, active low, registered
//   an_n[5:0]    anode selects, active low, registered; an_n[k] selects digit_k
//   frame_tick   one-cycle pulse at the start of each frame, registered
//
// Build option: define SEG7_SCAN_DIM_EN to add the bright input and the
// 4-bit PWM dimmer.
module seg7_scan #(
  parameter int DIV   = 1000,
  parameter int BLANK = 16
) (
  input  logic       m_clock,
  input  logic       p_reset,
  input  logic [7:0] digit_0,
  input  logic [7:0] digit_1,
  input  logic [7:0] digit_2,
  input  logic [7:0] digit_3,
  input  logic [7:0] digit_4,
  input  logic [7:0] digit_5,
  input  logic       enable,
`ifdef SEG7_SCAN_DIM_EN
  input  logic [3:0] bright,
`endif
  output logic [7:0] seg_n,
  output logic [5:0] an_n,
  output logic       frame_tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [5:0][7:0] snap;
  logic [5:0][7:0] din;
  logic            cnt_last;
  logic            lit;
  logic            lit_on;

  assign din      = {digit_5, digit_4, digit_3, digit_2, digit_1, digit_0};
  assign cnt_last = (cnt == CW'(DIV - 1));
  // The lit phase is decided from the current state; the output registers
  // below then present it one cycle later with no combinational glitches.
  assign lit      = enable && (cnt >= CW'(BLANK));

`ifdef SEG7_SCAN_DIM_EN
  logic [3:0] pwm;
  logic [3:0] bright_q;

  assign lit_on = lit && (pwm < bright_q);

  // Free-running, independent of enable, so the duty pattern never stalls.
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      pwm      <= 4'd0;
      bright_q <= 4'd0;
    end else begin
      pwm <= pwm + 4'd1;
      // bright travels with the digit snapshot so a frame has one duty.
      if (!enable || (cnt_last && idx == 3'd5)) bright_q <= bright;
    end
  end
`else
  assign lit_on = lit;
`endif

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      cnt        <= '0;
      idx        <= 3'd0;
      snap       <= '0;
      seg_n      <= 8'hFF;
      an_n       <= 6'h3F;
      frame_tick <= 1'b0;
    end else begin
      if (!enable) begin
        // Held scan keeps tracking the inputs, so a restart shows fresh data.
        cnt  <= '0;
        idx  <= 3'd0;
        snap <= din;
      end else if (cnt_last) begin
        cnt <= '0;
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        if (idx == 3'd5) snap <= din;
      end else begin
        cnt <= cnt + CW'(1);
      end

      frame_tick <= enable && (cnt == '0) && (idx == 3'd0);
      seg_n      <= lit_on ? ~snap[idx] : 8'hFF;
      an_n       <= lit_on ? ~(6'b1 << idx) : 6'h3F;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan (DIV=8, BLANK=2). Every clocked step pushes the
// outputs the display should show after that edge into a queue; the step then
// pops and compares them just after the edge.
module tb_seg7_scan;
  localparam int DIV   = 8;
  localparam int BLANK = 2;

  logic       m_clock = 1'b0;
  logic       p_reset = 1'b0;
  logic       enable  = 1'b0;
  logic [7:0] digit_0, digit_1, digit_2, digit_3, digit_4, digit_5;
  logic [7:0] seg_n;
  logic [5:0] an_n;
  logic       frame_tick;
`ifdef SEG7_SCAN_DIM_EN
  logic [3:0] bright = 4'd15;
`endif

  int n_asrt = 0;
  int n_fail = 0;
  int pwm_m  = 0;   // expected PWM counter value at the next edge
  int bright_m = 15; // brightness held in the DUT snapshot

  typedef struct packed {
    logic [7:0] seg;
    logic [5:0] an;
    logic       tick;
  } exp_t;
  exp_t sb[$];

  seg7_scan #(.DIV(DIV), .BLANK(BLANK)) dut (
    .m_clock   (m_clock),
    .p_reset   (p_reset),
    .digit_0   (digit_0),
    .digit_1   (digit_1),
    .digit_2   (digit_2),
    .digit_3   (digit_3),
    .digit_4   (digit_4),
    .digit_5   (digit_5),
    .enable    (enable),
`ifdef SEG7_SCAN_DIM_EN
    .bright    (bright),
`endif
    .seg_n     (seg_n),
    .an_n      (an_n),
    .frame_tick(frame_tick)
  );

  always #5 m_clock = ~m_clock;

  // At most one anode may be driven in any cycle.
  always @(negedge m_clock) begin
    n_asrt++;
    assert ($onehot0(~an_n)) else begin
      n_fail++;
      $error("FAIL an_onehot: observed an_n=%b required one-hot-or-none", an_n);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asrt++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_blank(input logic t);
    sb.push_back('{seg: 8'hFF, an: 6'h3F, tick: t});
  endtask

  // One clock edge; compare the DUT against the oldest queued expectation.
  task automatic tick();
    exp_t e;
    @(posedge m_clock);
    if (!p_reset) pwm_m = (pwm_m + 1) % 16;
    #1;
    n_asrt++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL sb_empty: observed 0 queued expected >0");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("seg_n", 32'(seg_n), 32'(e.seg));
      check("an_n", 32'(an_n), 32'(e.an));
      check("frame_tick", 32'(frame_tick), 32'(e.tick));
    end
  endtask

  // Cycle c of the slot for digit k, whose snapshotted pattern is v.
  task automatic slot_cycle(input int k, input logic [7:0] v, input int c);
    logic on;
    logic [5:0] an_e;
    if (c < BLANK) begin
      push_blank(k == 0 && c == 0);
    end else begin
      on = 1'b1;
`ifdef SEG7_SCAN_DIM_EN
      on = (pwm_m < bright_m);
`endif
      an_e = 6'h3F;
      an_e[k] = 1'b0;
      if (on) sb.push_back('{seg: ~v, an: an_e, tick: 1'b0});
      else    push_blank(1'b0);
    end
    tick();
  endtask

  task automatic run_slot(input int k, input logic [7:0] v);
    for (int c = 0; c < DIV; c++) slot_cycle(k, v, c);
  endtask

  initial begin
    digit_0 = 8'h3F; digit_1 = 8'h40; digit_2 = 8'h41;
    digit_3 = 8'h42; digit_4 = 8'h43; digit_5 = 8'h44;

    // Reset acts with no clock edge.
    #1 p_reset = 1'b1;
    #1;
    check("rst_seg", 32'(seg_n), 32'h FF);
    check("rst_an", 32'(an_n), 32'h3F);
    check("rst_tick", 32'(frame_tick), 32'h0);
    @(posedge m_clock);
    @(posedge m_clock);
    #1 p_reset = 1'b0;

    // Held: dark, snapshot follows inputs.
    push_blank(1'b0); tick();
    push_blank(1'b0); tick();

    // Scan order, then wrap back to digit 0 (tick 48 cycles later).
    enable = 1'b1;
    for (int k = 0; k < 6; k++) run_slot(k, 8'h3F + 8'(k));

    // Frame coherence: the new digit_0 only appears in the following frame.
    digit_0 = 8'h06;
    for (int k = 0; k < 6; k++) run_slot(k, 8'h3F + 8'(k));
    run_slot(0, 8'h06);
    run_slot(1, 8'h40);
    run_slot(2, 8'h41);
    for (int c = 0; c < 4; c++) slot_cycle(3, 8'h42, c);
    digit_0 = 8'h5B;
    for (int c = 4; c < DIV; c++) slot_cycle(3, 8'h42, c);
    run_slot(4, 8'h43);
    run_slot(5, 8'h44);
    run_slot(0, 8'h5B);
    run_slot(1, 8'h40);

    // Enable drop in slot 2, cycle 5; restart at digit 0 with fresh data.
    for (int c = 0; c < 5; c++) slot_cycle(2, 8'h41, c);
    enable = 1'b0;
    push_blank(1'b0); tick();
    digit_0 = 8'h77;
    push_blank(1'b0); tick();
    push_blank(1'b0); tick();
    enable = 1'b1;
    run_slot(0, 8'h77);

    // Reset mid-slot: outputs dark at once, frame discarded, snapshot cleared.
    for (int c = 0; c < 4; c++) slot_cycle(1, 8'h40, c);
    p_reset = 1'b1;
    pwm_m = 0;
    #1;
    check("mid_rst_seg", 32'(seg_n), 32'hFF);
    check("mid_rst_an", 32'(an_n), 32'h3F);
    check("mid_rst_tick", 32'(frame_tick), 32'h0);
    push_blank(1'b0); tick();
    p_reset = 1'b0;
`ifdef SEG7_SCAN_DIM_EN
    bright_m = 0;
`endif
    run_slot(0, 8'h00);
    run_slot(1, 8'h00);

`ifdef SEG7_SCAN_DIM_EN
    // Dimming: bright=4 lights only while pwm is 0..3; bright=0 stays dark.
    enable = 1'b0;
    bright = 4'd4;
    push_blank(1'b0); tick();
    bright_m = 4;
    enable = 1'b1;
    for (int k = 0; k < 6; k++) run_slot(k, 8'h3F + 8'(k));
    enable = 1'b0;
    bright = 4'd0;
    push_blank(1'b0); tick();
    bright_m = 0;
    enable = 1'b1;
    run_slot(0, 8'h5B);
    run_slot(1, 8'h40);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
